// File: rtl/spu_axi_rd_responder.sv
// AXI4 read-channel responder: unrolls one AR burst into req/gnt memory reads, returns R beats
// through a 2-entry buffer. Optional AR legality checking: SPU_RD_RESPONDER_BURST_CHECK_EN.
module spu_axi_rd_responder #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StBurst, StDrain, StErr} state_e;

  state_e                 state_q, state_d;
  logic                   ar_ready_q;
  logic [IdWidth-1:0]     id_q;
  logic [AddrWidth-1:0]   addr_q, addr_d, wrap_lo_q, wrap_bytes_q;
  logic [7:0]             len_q, cnt_q, cnt_d;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic                   infl_q, infl_last_q;
  logic [DataWidth-1:0]   buf_data_q [2];
  logic                   buf_last_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q;

  logic                   ar_hs, ar_illegal, grant, push, pop, buf_valid, credit;
  logic [AddrWidth-1:0]   step, ar_step, ar_aligned, ar_wrap_bytes, ar_wrap_lo, incr_addr;

  function automatic logic [3:0] flog2(input logic [8:0] v);
    flog2 = '0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) flog2 = 4'(i);
    end
  endfunction

  assign ar_hs         = ar_valid_i & ar_ready_q;
  assign ar_step       = AddrWidth'(1) << ar_size_i;
  assign ar_aligned    = ar_addr_i & ~(ar_step - AddrWidth'(1));
  // Non power-of-two WRAP lengths fall back to the next lower power-of-two window.
  assign ar_wrap_bytes = AddrWidth'(1) << (5'(ar_size_i) + 5'(flog2(9'(ar_len_i) + 9'd1)));
  assign ar_wrap_lo    = ar_addr_i & ~(ar_wrap_bytes - AddrWidth'(1));

`ifdef SPU_RD_RESPONDER_BURST_CHECK_EN
  localparam int unsigned MaxSize = $clog2(DataWidth / 8);
  always_comb begin
    ar_illegal = 1'b0;
    if (ar_burst_i == BurstWrap &&
        (!(ar_len_i == 8'd1 || ar_len_i == 8'd3 || ar_len_i == 8'd7 || ar_len_i == 8'd15) ||
         (ar_addr_i & (ar_step - AddrWidth'(1))) != '0)) begin
      ar_illegal = 1'b1;
    end
    if (ar_size_i > 3'(MaxSize)) ar_illegal = 1'b1;
  end
`else
  assign ar_illegal = 1'b0;
`endif

  assign step      = AddrWidth'(1) << size_q;
  assign incr_addr = addr_q + step;
  assign buf_valid = (occ_q != 2'd0);
  assign pop       = buf_valid & r_ready_i;
  assign push      = infl_q & mem_rvalid_i;
  // Counting this cycle's pop keeps one beat per cycle flowing without overflowing the buffer.
  assign credit    = ({1'b0, occ_q} - {2'b0, pop} + {2'b0, infl_q}) < 3'd2;
  assign grant     = mem_req_o & mem_gnt_i;

  always_comb begin
    addr_d = incr_addr;
    if (burst_q == BurstFixed) begin
      addr_d = addr_q;
    end else if (burst_q == BurstWrap && (incr_addr - wrap_lo_q) >= wrap_bytes_q) begin
      addr_d = incr_addr - wrap_bytes_q;
    end
  end

  always_comb begin
    ar_ready_o = ar_ready_q;
    mem_req_o  = (state_q == StBurst) & credit;
    mem_addr_o = addr_q;
    r_id_o     = id_q;
    r_valid_o  = buf_valid;
    r_data_o   = buf_data_q[rd_ptr_q];
    r_last_o   = buf_valid & buf_last_q[rd_ptr_q];
    r_resp_o   = RespOkay;
    if (state_q == StErr) begin
      r_valid_o = 1'b1;
      r_data_o  = '0;
      r_last_o  = (cnt_q == len_q);
      r_resp_o  = RespSlvErr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          cnt_d   = '0;
          state_d = ar_illegal ? StErr : StBurst;
        end
      end
      StBurst: begin
        if (grant) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && r_last_o) state_d = StIdle;
      end
      StErr: begin
        if (r_ready_i) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ar_ready_q   <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      wrap_lo_q    <= '0;
      wrap_bytes_q <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      cnt_q        <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      ar_ready_q  <= (state_d == StIdle);
      cnt_q       <= cnt_d;
      infl_q      <= grant;
      infl_last_q <= (cnt_q == len_q);
      if (ar_hs) begin
        id_q         <= ar_id_i;
        addr_q       <= ar_aligned;
        wrap_lo_q    <= ar_wrap_lo;
        wrap_bytes_q <= ar_wrap_bytes;
        len_q        <= ar_len_i;
        size_q       <= ar_size_i;
        burst_q      <= ar_burst_i;
      end else if (grant) begin
        addr_q <= addr_d;
      end
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_rdata_i;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_spu_axi_rd_responder.sv
// Directed, table-driven bench for spu_axi_rd_responder with a one-cycle-latency memory model.
module tb_spu_axi_rd_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  spu_axi_rd_responder #(.AddrWidth(32), .DataWidth(64), .IdWidth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    int               stall;
    bit               slow_gnt;
    bit               err;
    logic [7:0][31:0] ea;  // element 0 is the rightmost in the literal
  } vec_t;

  vec_t vecs[10];
  int   nvec;

  function automatic logic [63:0] fdat(input logic [31:0] a);
    return {a ^ 32'hA5A5_0F0F, ~a};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    chk("ar_ready_idle", ar_ready, 1'b1);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          grants, beats, max_out, first_r;
    bit          done, pg, pstall_r, pwait_m;
    logic [31:0] pa, pmaddr;
    logic [63:0] pdata;
    logic        plast, exp_last;
    grants = 0; beats = 0; max_out = 0; first_r = -1; done = 0;
    pg = 0; pstall_r = 0; pwait_m = 0; pa = '0; pmaddr = '0; pdata = '0; plast = 0;
    do_ar(v.id, v.addr, v.len, v.size, v.burst);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      mem_rvalid = pg;
      mem_rdata  = fdat(pa);
      r_ready    = (cyc > v.stall);
      mem_gnt    = v.slow_gnt ? ((cyc % 3) != 1) : 1'b1;
      #1;
      if (cyc == 1) chk("ar_ready_low_req", {ar_ready, mem_req}, {1'b0, !v.err});
      if (pwait_m && mem_req) chk("mem_addr_stable", mem_addr, pmaddr);
      if (pstall_r) chk("r_stable", {r_valid, r_last, r_data}, {1'b1, plast, pdata});
      pg = mem_req & mem_gnt;
      pa = mem_addr;
      if (pg) begin
        if (v.err || grants > 7) chk("unexpected_grant", 1'b1, 1'b0);
        else chk($sformatf("mem_addr[%0d]", grants), mem_addr, v.ea[grants]);
        grants++;
      end
      if (r_valid && r_ready) begin
        if (first_r < 0) first_r = cyc;
        exp_last = (beats == int'(v.len));
        chk($sformatf("r_beat[%0d]", beats), {r_id, r_resp, r_last, r_data},
            {v.id, v.err ? 2'b10 : 2'b00, exp_last,
             (v.err || beats > 7) ? 64'h0 : fdat(v.ea[beats])});
        beats++;
        if (r_last) done = 1;
      end
      if (grants - beats > max_out) max_out = grants - beats;
      pwait_m  = mem_req & !mem_gnt;
      pmaddr   = mem_addr;
      pstall_r = r_valid & !r_ready;
      pdata    = r_data;
      plast    = r_last;
      @(posedge clk); #1;
    end
    if (!done) chk("burst_timeout", 1'b0, 1'b1);
    mem_rvalid = pg;
    mem_rdata  = fdat(pa);
    #1;
    chk("ar_ready_after_last", ar_ready, 1'b1);
    chk("grant_count", grants, v.err ? 0 : int'(v.len) + 1);
    chk("beat_count", beats, int'(v.len) + 1);
    chk("max_outstanding_le2", max_out <= 2, 1'b1);
    if (!v.err && v.stall == 0 && !v.slow_gnt) chk("ar_to_first_r", first_r, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      #1;
      chk("idle_quiet", {r_valid, mem_req}, 2'b00);
    end
  endtask

  initial begin
    int beats;
    bit pg;
    logic [31:0] pa;
    rst_n = 1'b0; ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    r_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    nvec = 0;
    vecs[nvec] = '{4'h5, 32'h1004, 8'd3, 3'd3, 2'b01, 0, 0, 0,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h1018, 32'h1010, 32'h1008, 32'h1000}};
    nvec++;
    vecs[nvec] = '{4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 0, 0, 0,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h34, 32'h30, 32'h3C, 32'h38}};
    nvec++;
    vecs[nvec] = '{4'h9, 32'h20, 8'd2, 3'd3, 2'b00, 0, 0, 0,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h20, 32'h20, 32'h20}};
    nvec++;
    vecs[nvec] = '{4'hA, 32'h200, 8'd7, 3'd3, 2'b01, 10, 0, 0,
                   {32'h238, 32'h230, 32'h228, 32'h220, 32'h218, 32'h210, 32'h208, 32'h200}};
    nvec++;
    vecs[nvec] = '{4'h3, 32'h103, 8'd0, 3'd2, 2'b01, 0, 0, 0,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100}};
    nvec++;
    vecs[nvec] = '{4'h6, 32'h48, 8'd1, 3'd3, 2'b10, 0, 1, 0,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h48}};
    nvec++;
    vecs[nvec] = '{4'hC, 32'hFFFF_FFFE, 8'd4, 3'd0, 2'b01, 2, 1, 0,
                   {32'h0, 32'h0, 32'h0, 32'h2, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
    nvec++;
`ifdef SPU_RD_RESPONDER_BURST_CHECK_EN
    vecs[nvec] = '{4'h7, 32'h40, 8'd2, 3'd2, 2'b10, 1, 0, 1,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    nvec++;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ar_ready, r_valid, mem_req, r_last, r_resp, r_id, mem_addr, r_data}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_ready_after_release", {ar_ready, r_valid, mem_req}, 3'b100);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

    // Reset in the middle of an INCR len 7 burst, after two beats have been delivered.
    beats = 0; pg = 0; pa = '0;
    do_ar(4'hB, 32'h300, 8'd7, 3'd3, 2'b01);
    for (int cyc = 0; cyc < 50 && beats < 2; cyc++) begin
      mem_rvalid = pg; mem_rdata = fdat(pa); r_ready = 1'b1; mem_gnt = 1'b1;
      #1;
      pg = mem_req & mem_gnt;
      pa = mem_addr;
      if (r_valid && r_ready) beats++;
      @(posedge clk); #1;
    end
    chk("midburst_beats", beats, 2);
    rst_n = 1'b0; mem_rvalid = 1'b0; r_ready = 1'b0;
    #1;
    chk("reset_midburst", {ar_ready, r_valid, mem_req, r_last, r_resp, r_id, mem_addr, r_data}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("post_reset_idle", {ar_ready, r_valid, mem_req}, 3'b100);
    @(posedge clk); #1;
    chk("stray_rvalid_ignored", r_valid, 1'b0);
    run_vec('{4'h4, 32'h500, 8'd0, 3'd3, 2'b01, 0, 0, 0,
              {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h500}});

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/spu_axi_rd_responder.md
# spu_axi_rd_responder

AXI4 read-channel responder (subordinate side) for SPU-attached memories. It accepts one AR burst at a time and unrolls it into per-beat word requests on a simple req/gnt memory port, computing FIXED/INCR/WRAP beat addresses per AXI A3-51. It returns the data on the R channel with correct `rid` and `rlast`, absorbing R back-pressure in a 2-entry response buffer. It is the receiving end of the read bursts issued by SPU AXI initiators and uses the `spu_pkg` burst, size, len and resp types.

## Interface
- `AddrWidth`, 32, byte-address width of AR and memory port.
- `DataWidth`, 64, R/memory data width; power of two, 8..1024.
- `IdWidth`, 4, AXI ID width.
- `clk_i` in 1: clock. One clock domain; reset is asynchronous and active-low.
- `rst_ni` in 1: asynchronous active-low reset.
- `ar_valid_i` in 1 / `ar_ready_o` out 1: AR handshake.
- `ar_id_i` in IdWidth, `ar_addr_i` in AddrWidth, `ar_len_i` in 8 (`len_t`), `ar_size_i` in 3 (`size_t`), `ar_burst_i` in 2 (`burst_t`): AR payload.
- `r_valid_o` out 1 / `r_ready_i` in 1: R handshake.
- `r_id_o` out IdWidth, `r_data_o` out DataWidth, `r_resp_o` out 2 (`resp_t`), `r_last_o` out 1: R payload.
- `mem_req_o` out 1 / `mem_gnt_i` in 1: memory request handshake.
- `mem_addr_o` out AddrWidth: beat byte address.
- `mem_rvalid_i` in 1, `mem_rdata_i` in DataWidth: read data, exactly one cycle after each grant.

## Operation
- FSM states: IDLE, BURST, DRAIN, ERR.
  - IDLE: `ar_ready_o`=1. On handshake, latch id/addr/len/size/burst, beat counter := 0, and go to BURST. In ERR-check builds, an illegal request goes to ERR instead.
  - BURST: `mem_req_o`=1 while credit is available. Each grant advances the beat address and issue counter. On the grant of beat `len`, go to DRAIN.
  - DRAIN: stop requesting. After the R handshake with `r_last_o`=1, go to IDLE.
  - ERR: emit len+1 R beats with `r_resp_o`=RESP_SLVERR and `r_data_o`=0, with no memory access. After the last handshake, go to IDLE.
- Credit rule: request only when (buffer occupancy + requests in flight) < 2. The buffer never overflows, and `mem_rvalid_i` is never dropped.
- Beat address rules:
  - Beat 0: `aligned = (addr >> size) << size`; `mem_addr_o` = `aligned`.
  - FIXED: every beat uses `aligned`.
  - INCR: next = current + (1 << size), computed modulo 2^AddrWidth. There is no 4 KiB check.
  - WRAP: wrap boundary = addr with the low (size + log2(len+1)) bits cleared. If next ≥ boundary + (1<<size)·(len+1), then next -= (1<<size)·(len+1).
- Each buffer entry carries data and last (last = issue count equals len).
- `r_id_o` is the latched id for the whole burst. `r_resp_o` is RESP_OKAY outside ERR.
- Data is passed unshifted. Narrow-beat lane selection is the initiator's responsibility.

## Timing
- Reset values: `ar_ready_o`=0 during reset, then 1 in IDLE from the first cycle after release. All other outputs are 0. The buffer is empty and the FSM is in IDLE.
- AR handshake at cycle T: `mem_req_o` asserts at T+1.
- Grant at G: data enters the buffer at G+1, and `r_valid_o` asserts at G+2 (registered buffer, no fall-through).
- Minimum AR→first R is 3 cycles. Sustained throughput is 1 beat/cycle with `mem_gnt_i`=1 and `r_ready_i`=1.
- `ar_ready_o` is 0 from the AR handshake until the cycle after the last R handshake, so the next AR is accepted at the earliest 1 cycle after `rlast`.
- `mem_addr_o` is stable while `mem_req_o`=1 and no grant has occurred.
- `r_*` outputs are stable while `r_valid_o`=1 and `r_ready_i`=0.
- Buffer push and pop in the same cycle is allowed; occupancy is unchanged.
- Reset asserted mid-burst immediately clears the FSM, counters and buffer. Any `mem_rvalid_i` arriving after release is ignored.

## Configuration
- Macro: `SPU_RD_RESPONDER_BURST_CHECK_EN`.
- When defined, an AR is illegal if either:
  - WRAP with len ∉ {1,3,7,15}, or with `ar_addr_i` not aligned to size;
  - `1<<ar_size_i` > DataWidth/8.
- An illegal AR goes to ERR and returns len+1 SLVERR beats.
- When undefined, there is no checking and ERR is unreachable (it may be removed). Illegal WRAP lengths use the boundary computed with log2 of len+1 rounded down, and oversize requests are served as given.

## Test plan
- INCR, addr 0x1004, size 3, len 3: `mem_addr_o` 0x1000, 0x1008, 0x1010, 0x1018; 4 OKAY beats; `rlast` only on beat 4; `rid` echoed.
- WRAP, addr 0x38, size 2, len 3: addresses 0x38, 0x3C, 0x30, 0x34; data returned in that order.
- FIXED, addr 0x20, size 3, len 2: three requests, all at 0x20.
- INCR len 7 with `r_ready_i`=0 for 10 cycles: at most 2 grants outstanding or buffered; after release, all 8 beats arrive in order with no loss or duplication.
- With `SPU_RD_RESPONDER_BURST_CHECK_EN`, WRAP len 2: zero `mem_req_o`; 3 beats, each SLVERR with data 0; `rlast` on beat 3; next AR accepted afterwards.
- Assert `rst_ni` after beat 2 of an INCR len 7 burst: all outputs 0 during reset; after release, `ar_ready_o`=1; a new INCR len 0 returns exactly one beat.
